// File: rtl/ddr_cmd_responder.sv
// DDR4 command-bus responder: decodes sampled command pins, tracks per-bank open state,
// row and tRCD progress, flags protocol violations and generates read/write data windows.
module ddr_cmd_responder #(
  parameter int unsigned T_RCD      = 4,
  parameter int unsigned RL         = 13,
  parameter int unsigned WL         = 10,
  parameter int unsigned BURST_CLKS = 4
) (
  input  logic        clock_t_i,
  input  logic        reset_n_i,
  input  logic        cs_n_i,
  input  logic        act_n_i,
  input  logic        ras_n_a16_i,
  input  logic        cas_n_a15_i,
  input  logic        we_n_a14_i,
  input  logic [1:0]  bg_i,
  input  logic [1:0]  ba_i,
  input  logic [13:0] addr_i,
  output logic        cmd_valid_o,
  output logic [2:0]  cmd_code_o,
  output logic [3:0]  cmd_bank_o,
  output logic [16:0] cmd_row_o,
  output logic [9:0]  cmd_col_o,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic        rd_data_en_o,
  output logic        wr_data_en_o,
  output logic [15:0] bank_open_o
);

  localparam int unsigned CntW = (T_RCD < 1) ? 1 : $clog2(T_RCD + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(T_RCD);
  localparam int unsigned RdW = RL + BURST_CLKS;
  localparam int unsigned WrW = WL + BURST_CLKS;
  // Bit k of a window shifter reaches bit 0 k clocks after the command's cmd_valid clock.
  localparam logic [RdW-1:0] RdMask = {{BURST_CLKS{1'b1}}, {RL{1'b0}}};
  localparam logic [WrW-1:0] WrMask = {{BURST_CLKS{1'b1}}, {WL{1'b0}}};

  typedef enum logic [2:0] {
    CmdAct  = 3'd0,
    CmdRd   = 3'd1,
    CmdWr   = 3'd2,
    CmdPre  = 3'd3,
    CmdPrea = 3'd4,
    CmdRef  = 3'd5,
    CmdMrs  = 3'd6,
    CmdZqc  = 3'd7
  } cmd_e;

  logic        cmd_hit;
  cmd_e        cmd;
  logic [3:0]  bank;
  logic [16:0] act_row;
  logic [2:0]  err_cls;
  logic        legal;

  logic [15:0]     open_q, open_d;
  logic [16:0]     row_q [16];
  logic [16:0]     row_d [16];
  logic [CntW-1:0] cnt_q [16];
  logic [CntW-1:0] cnt_d [16];
  logic [RdW-1:0]  rd_sr_q, rd_sr_d;
  logic [WrW-1:0]  wr_sr_q, wr_sr_d;

  logic        cmd_valid_q, cmd_valid_d;
  logic [2:0]  cmd_code_q, cmd_code_d;
  logic [3:0]  cmd_bank_q, cmd_bank_d;
  logic [16:0] cmd_row_q, cmd_row_d;
  logic [9:0]  cmd_col_q, cmd_col_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;

  assign bank    = {bg_i, ba_i};
  assign act_row = {ras_n_a16_i, cas_n_a15_i, we_n_a14_i, addr_i};

  // Decode the command pins; DES and NOP leave cmd_hit low.
  always_comb begin
    cmd_hit = 1'b0;
    cmd     = CmdAct;
    if (!cs_n_i) begin
      cmd_hit = 1'b1;
      if (!act_n_i) begin
        cmd = CmdAct;
      end else begin
        unique case ({ras_n_a16_i, cas_n_a15_i, we_n_a14_i})
          3'b000:  cmd = CmdMrs;
          3'b001:  cmd = CmdRef;
          3'b010:  cmd = addr_i[10] ? CmdPrea : CmdPre;
          3'b011:  cmd = CmdZqc;
          3'b100:  cmd = CmdWr;
          3'b101:  cmd = CmdRd;
          3'b110:  cmd = CmdZqc;
          default: cmd_hit = 1'b0;
        endcase
      end
    end
  end

  // Classify protocol violations; each command type can only hit one class.
  always_comb begin
    err_cls = 3'd0;
    if (cmd_hit) begin
      case (cmd)
        CmdRd, CmdWr: begin
          if (!open_q[bank])              err_cls = 3'd1;
          else if (cnt_q[bank] < CntMax)  err_cls = 3'd3;
        end
        CmdAct:         if (open_q[bank]) err_cls = 3'd2;
        CmdRef, CmdMrs: if (|open_q)      err_cls = 3'd4;
        default: ;
      endcase
    end
    legal = cmd_hit && (err_cls == 3'd0);
  end

  // Bank bookkeeping and data-window shifters; bank commands override the tRCD increment.
  always_comb begin
    open_d = open_q;
    for (int i = 0; i < 16; i++) begin
      row_d[i] = row_q[i];
      cnt_d[i] = (cnt_q[i] == CntMax) ? cnt_q[i] : cnt_q[i] + 1'b1;
    end
    rd_sr_d = rd_sr_q >> 1;
    wr_sr_d = wr_sr_q >> 1;
    if (legal) begin
      case (cmd)
        CmdAct: begin
          open_d[bank] = 1'b1;
          row_d[bank]  = act_row;
          cnt_d[bank]  = '0;
        end
        CmdPre: begin
          open_d[bank] = 1'b0;
          cnt_d[bank]  = cnt_q[bank];
        end
        CmdPrea: begin
          open_d = '0;
          for (int i = 0; i < 16; i++) cnt_d[i] = cnt_q[i];
        end
        CmdRd:   rd_sr_d = rd_sr_d | RdMask;
        CmdWr:   wr_sr_d = wr_sr_d | WrMask;
        default: ;
      endcase
    end
  end

  // Registered command report; err_code is sticky between violations.
  always_comb begin
    cmd_valid_d = cmd_hit;
    cmd_code_d  = cmd_hit ? 3'(cmd) : 3'd0;
    cmd_bank_d  = cmd_hit ? bank : 4'd0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    if (cmd_hit) begin
      cmd_row_d = (cmd == CmdAct) ? act_row : row_q[bank];
      if (cmd == CmdRd || cmd == CmdWr) cmd_col_d = addr_i[9:0];
    end
    err_d      = cmd_hit && (err_cls != 3'd0);
    err_code_d = err_d ? err_cls : err_code_q;
  end

  // State register with asynchronous clear of banks, windows and outputs.
  always_ff @(posedge clock_t_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      open_q      <= '0;
      rd_sr_q     <= '0;
      wr_sr_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        row_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      open_q      <= open_d;
      rd_sr_q     <= rd_sr_d;
      wr_sr_q     <= wr_sr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      for (int i = 0; i < 16; i++) begin
        row_q[i] <= row_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_code_o   = cmd_code_q;
  assign cmd_bank_o   = cmd_bank_q;
  assign cmd_row_o    = cmd_row_q;
  assign cmd_col_o    = cmd_col_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign rd_data_en_o = rd_sr_q[0];
  assign wr_data_en_o = wr_sr_q[0];
  assign bank_open_o  = open_q;

endmodule

// File: tb/tb_ddr_cmd_responder.sv
// Scoreboard bench for ddr_cmd_responder: directed scenarios followed by random traffic,
// checked against a cycle-indexed behavioural model of banks and data windows.
module tb_ddr_cmd_responder;

  localparam int T_RCD = 4;
  localparam int RL    = 13;
  localparam int WL    = 10;
  localparam int BURST = 4;
  localparam int MAXC  = 4096;

  localparam int K_ACT = 0, K_RD = 1, K_WR = 2, K_PRE = 3, K_PREA = 4;
  localparam int K_REF = 5, K_MRS = 6, K_RFU = 7, K_DES = 8, K_NOP = 9;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs_n, act_n, ras, cas, we;
  logic [1:0]  bg, ba;
  logic [13:0] addr;
  logic        cmd_valid, err, rd_en, wr_en;
  logic [2:0]  cmd_code, err_code;
  logic [3:0]  cmd_bank;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] bank_open;

  ddr_cmd_responder #(
    .T_RCD      (T_RCD),
    .RL         (RL),
    .WL         (WL),
    .BURST_CLKS (BURST)
  ) dut (
    .clock_t_i    (clk),
    .reset_n_i    (reset_n),
    .cs_n_i       (cs_n),
    .act_n_i      (act_n),
    .ras_n_a16_i  (ras),
    .cas_n_a15_i  (cas),
    .we_n_a14_i   (we),
    .bg_i         (bg),
    .ba_i         (ba),
    .addr_i       (addr),
    .cmd_valid_o  (cmd_valid),
    .cmd_code_o   (cmd_code),
    .cmd_bank_o   (cmd_bank),
    .cmd_row_o    (cmd_row),
    .cmd_col_o    (cmd_col),
    .err_o        (err),
    .err_code_o   (err_code),
    .rd_data_en_o (rd_en),
    .wr_data_en_o (wr_en),
    .bank_open_o  (bank_open)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  code;
    logic [3:0]  bank;
    logic [16:0] row;
    logic [9:0]  col;
    logic        err;
    logic [2:0]  errc;
  } exp_t;

  exp_t exp_q[$];
  logic        exp_rd   [MAXC];
  logic        exp_wr   [MAXC];
  logic [15:0] exp_open [MAXC];

  // Model state: open flags, stored rows, clock of the last legal ACT, sticky error class.
  logic [15:0] m_open;
  logic [16:0] m_row [16];
  int          m_act [16];
  logic [2:0]  m_errc;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
  endtask

  task automatic model_clear();
    m_open = '0;
    m_errc = '0;
    for (int i = 0; i < 16; i++) begin
      m_row[i] = '0;
      m_act[i] = 0;
    end
  endtask

  // Drive one command for the next rising edge, record its expected effects, advance a clock.
  task automatic issue(input int kind, input logic [3:0] b, input logic [16:0] row,
                       input logic [9:0] col);
    int         n;
    exp_t       e;
    logic [2:0] cls;
    logic [2:0] rwe;
    n     = cyc + 1;
    bg    = b[3:2];
    ba    = b[1:0];
    cs_n  = 1'b0;
    act_n = 1'b1;
    addr  = 14'($urandom);
    rwe   = 3'($urandom);
    case (kind)
      K_ACT:  begin act_n = 1'b0; {ras, cas, we, addr} = row; end
      K_RD:   rwe = 3'b101;
      K_WR:   rwe = 3'b100;
      K_PRE:  begin rwe = 3'b010; addr[10] = 1'b0; end
      K_PREA: begin rwe = 3'b010; addr[10] = 1'b1; end
      K_REF:  rwe = 3'b001;
      K_MRS:  rwe = 3'b000;
      K_RFU:  rwe = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b110;
      K_NOP:  rwe = 3'b111;
      default: cs_n = 1'b1;
    endcase
    if (kind != K_ACT) {ras, cas, we} = rwe;
    if (kind == K_RD || kind == K_WR) addr[9:0] = col;

    if (kind <= K_RFU) begin
      cls = 3'd0;
      case (kind)
        K_ACT: if (m_open[b]) cls = 3'd2;
        K_RD, K_WR: begin
          if (!m_open[b]) cls = 3'd1;
          else if (n - m_act[b] <= T_RCD) cls = 3'd3;
        end
        K_REF, K_MRS: if (m_open != 16'd0) cls = 3'd4;
        default: ;
      endcase
      e.cyc  = n;
      e.code = 3'(kind);
      e.bank = b;
      e.row  = (kind == K_ACT) ? row : m_row[b];
      e.col  = (kind == K_RD || kind == K_WR) ? col : 10'd0;
      e.err  = (cls != 3'd0);
      if (e.err) m_errc = cls;
      e.errc = m_errc;
      exp_q.push_back(e);
      if (!e.err) begin
        case (kind)
          K_ACT:  begin m_open[b] = 1'b1; m_row[b] = row; m_act[b] = n; end
          K_PRE:  m_open[b] = 1'b0;
          K_PREA: m_open = '0;
          K_RD:   for (int k = 0; k < BURST; k++) exp_rd[n + RL + k] = 1'b1;
          K_WR:   for (int k = 0; k < BURST; k++) exp_wr[n + WL + k] = 1'b1;
          default: ;
        endcase
      end
    end
    exp_open[n] = m_open;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) issue(K_DES, 4'd0, 17'd0, 10'd0);
  endtask

  // Assert reset just after an edge; everything in flight, modelled or not, is discarded.
  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    cs_n    = 1'b1;
    model_clear();
    exp_q.delete();
    for (int c = cyc; c < MAXC; c++) begin
      exp_rd[c]   = 1'b0;
      exp_wr[c]   = 1'b0;
      exp_open[c] = '0;
    end
    repeat (hold) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  int   mn;
  exp_t me;

  // Monitor: per-cycle window/bank checks, command reports popped from the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      mn = cyc;
      chk("rd_data_en", 32'(rd_en), 32'(exp_rd[mn]));
      chk("wr_data_en", 32'(wr_en), 32'(exp_wr[mn]));
      chk("bank_open", 32'(bank_open), 32'(exp_open[mn]));
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          chk("cmd_valid_unexpected", 32'(cmd_valid), 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("cmd_cycle", 32'(mn), 32'(me.cyc));
          chk("cmd_code", 32'(cmd_code), 32'(me.code));
          chk("cmd_bank", 32'(cmd_bank), 32'(me.bank));
          chk("cmd_row", 32'(cmd_row), 32'(me.row));
          chk("cmd_col", 32'(cmd_col), 32'(me.col));
          chk("err", 32'(err), 32'(me.err));
          chk("err_code", 32'(err_code), 32'(me.errc));
        end
      end else begin
        chk("err_idle", 32'(err), 32'd0);
        if (exp_q.size() > 0 && exp_q[0].cyc == mn) begin
          chk("cmd_valid_missing", 32'(cmd_valid), 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  int          r;
  logic [3:0]  rb;

  initial begin
    reset_n = 1'b1;
    cs_n = 1'b1; act_n = 1'b1; ras = 1'b1; cas = 1'b1; we = 1'b1;
    bg = '0; ba = '0; addr = '0;
    for (int c = 0; c < MAXC; c++) begin
      exp_rd[c] = 1'b0; exp_wr[c] = 1'b0; exp_open[c] = '0;
    end
    model_clear();
    #1;
    reset_n = 1'b0;
    mon_en  = 1'b1;
    @(negedge clk);
    chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("reset_cmd_code", 32'(cmd_code), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);
    chk("reset_bank_open", 32'(bank_open), 32'd0);
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ACT bank {bg=1,ba=2}, 4 idle clocks, legal RD.
    issue(K_ACT, 4'h6, 17'h0A011, 10'd0);
    idle(4);
    issue(K_RD, 4'h6, 17'd0, 10'h011);
    idle(20);
    issue(K_PREA, 4'h0, 17'd0, 10'd0);

    // RD too soon after ACT.
    issue(K_ACT, 4'h0, 17'h1234, 10'd0);
    idle(1);
    issue(K_RD, 4'h0, 17'd0, 10'h055);
    idle(20);
    issue(K_PRE, 4'h0, 17'd0, 10'd0);

    // RD to idle bank, double ACT, legal RD reports the first row.
    issue(K_RD, 4'h5, 17'd0, 10'h3FF);
    issue(K_ACT, 4'h5, 17'h1ABCD, 10'd0);
    issue(K_ACT, 4'h5, 17'h00777, 10'd0);
    idle(5);
    issue(K_RD, 4'h5, 17'd0, 10'h101);
    idle(20);
    issue(K_PRE, 4'h5, 17'd0, 10'd0);
    issue(K_PRE, 4'h5, 17'd0, 10'd0);

    // Two WRs four clocks apart merge into one 8-clock window.
    issue(K_ACT, 4'h3, 17'h00042, 10'd0);
    idle(4);
    issue(K_WR, 4'h3, 17'd0, 10'h010);
    idle(3);
    issue(K_WR, 4'h3, 17'd0, 10'h020);
    idle(20);

    // REF with banks open, PREA, then clean REF.
    issue(K_ACT, 4'h0, 17'h00100, 10'd0);
    issue(K_ACT, 4'hF, 17'h1FFFF, 10'd0);
    issue(K_REF, 4'h0, 17'd0, 10'd0);
    issue(K_PREA, 4'h0, 17'd0, 10'd0);
    issue(K_REF, 4'h0, 17'd0, 10'd0);
    issue(K_MRS, 4'h0, 17'd0, 10'd0);
    idle(3);

    // Reset two clocks after a legal RD kills the burst and the open bank.
    issue(K_ACT, 4'h2, 17'h00321, 10'd0);
    idle(4);
    issue(K_RD, 4'h2, 17'd0, 10'h0AA);
    idle(2);
    do_reset(3);
    issue(K_RD, 4'h2, 17'd0, 10'h0AA);
    idle(25);

    // Random traffic, mostly on four banks so legal RD/WR occur.
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      if      (r < 30) issue(K_DES, rb, 17'd0, 10'd0);
      else if (r < 33) issue(K_NOP, rb, 17'd0, 10'd0);
      else if (r < 50) issue(K_ACT, rb, 17'($urandom), 10'd0);
      else if (r < 63) issue(K_RD, rb, 17'd0, 10'($urandom));
      else if (r < 76) issue(K_WR, rb, 17'd0, 10'($urandom));
      else if (r < 86) issue(K_PRE, rb, 17'd0, 10'd0);
      else if (r < 89) issue(K_PREA, rb, 17'd0, 10'd0);
      else if (r < 92) issue(K_REF, rb, 17'd0, 10'd0);
      else if (r < 94) issue(K_MRS, rb, 17'd0, 10'd0);
      else             issue(K_RFU, rb, 17'd0, 10'd0);
    end
    idle(30);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
